// File: rtl/fir_tap_arbiter_if.sv
// Bundles the host, engine and tap-RAM signals of the tap arbiter into one interface.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever drives the requests and models the tap RAM.
interface fir_tap_arbiter_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    // Host (AXI-lite side) path
    logic                   eng_busy;
    logic                   h_req;
    logic                   h_we;
    logic [pADDR_WIDTH-1:0] h_addr;
    logic [pDATA_WIDTH-1:0] h_wdata;
    logic                   h_gnt;
    logic                   h_rvalid;
    logic [pDATA_WIDTH-1:0] h_rdata;
    logic                   h_err;

    // FIR engine fetch path
    logic                   e_req;
    logic [pADDR_WIDTH-1:0] e_addr;
    logic                   e_gnt;
    logic                   e_rvalid;
    logic [pDATA_WIDTH-1:0] e_rdata;

    // Tap RAM port
    logic [3:0]             tap_WE;
    logic                   tap_EN;
    logic [pDATA_WIDTH-1:0] tap_Di;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic [pDATA_WIDTH-1:0] tap_Do;

    modport slave (
        input  eng_busy, h_req, h_we, h_addr, h_wdata, e_req, e_addr, tap_Do,
        output h_gnt, h_rvalid, h_rdata, h_err, e_gnt, e_rvalid, e_rdata,
               tap_WE, tap_EN, tap_Di, tap_A
    );

    modport master (
        output eng_busy, h_req, h_we, h_addr, h_wdata, e_req, e_addr, tap_Do,
        input  h_gnt, h_rvalid, h_rdata, h_err, e_gnt, e_rvalid, e_rdata,
               tap_WE, tap_EN, tap_Di, tap_A
    );
endinterface

// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter: shares the single-port tap-coefficient RAM between the host
// (programming/readback) and the FIR engine (coefficient fetch).
// - The engine normally has priority. A host request that has been refused
//   MAX_WAIT cycles in a row gets priority for one grant.
// - Host addresses are range-checked and translated to tap-relative addresses.
// - Host writes are refused while the engine is busy.
// Optional macro FIR_TAP_ARB_STATS_EN adds the saturating host_stall_cnt and
// err_cnt outputs.
module fir_tap_arbiter #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11,
    parameter int TAP_BASE    = 'h20,
    parameter int MAX_WAIT    = 4
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    fir_tap_arbiter_if.slave      bus
`ifdef FIR_TAP_ARB_STATS_EN
    ,
    output logic [15:0]           host_stall_cnt,
    output logic [7:0]            err_cnt
`endif
);

    localparam int TAP_END = TAP_BASE + 4 * Tape_Num;
    localparam int WCW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        ENG_PRI  = 1'b0,
        HOST_PRI = 1'b1
    } state_t;

    // Identifies who a read issued last cycle belongs to, so tap_Do can be steered.
    typedef enum logic [1:0] {
        OWN_NONE     = 2'd0,
        OWN_HOST     = 2'd1,
        OWN_HOST_OOR = 2'd2,
        OWN_ENG      = 2'd3
    } owner_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    owner_t         owner_q, owner_d;
    logic           h_err_q, h_err_d;

    logic                   h_gnt, e_gnt;
    logic                   h_in_range, h_wr_blocked, h_refused;
    logic                   tap_en;
    logic [3:0]             tap_we;
    logic [pADDR_WIDTH-1:0] tap_a;
    logic [pDATA_WIDTH-1:0] tap_di;

    assign h_in_range   = (32'(bus.h_addr) >= 32'(TAP_BASE)) &&
                          (32'(bus.h_addr) <  32'(TAP_END));
    assign h_wr_blocked = bus.h_we & bus.eng_busy;
    assign h_refused    = bus.h_req & ~h_gnt;

    // Pick the single grant for this cycle and drive the RAM port from it.
    always_comb begin
        h_gnt  = 1'b0;
        e_gnt  = 1'b0;
        tap_en = 1'b0;
        tap_we = 4'h0;
        tap_a  = '0;
        tap_di = '0;
        case (state_q)
            ENG_PRI: begin
                e_gnt = bus.e_req;
                h_gnt = bus.h_req & ~bus.e_req;
            end
            HOST_PRI: begin
                h_gnt = bus.h_req;
                e_gnt = 1'b0;
            end
            default: begin
                h_gnt = 1'b0;
                e_gnt = 1'b0;
            end
        endcase
        if (h_gnt) begin
            // Out-of-range or blocked writes are accepted but never reach the RAM.
            if (h_in_range && !h_wr_blocked) begin
                tap_en = 1'b1;
                tap_a  = bus.h_addr - pADDR_WIDTH'(TAP_BASE);
                if (bus.h_we) begin
                    tap_we = 4'hF;
                    tap_di = bus.h_wdata;
                end
            end
        end else if (e_gnt) begin
            tap_en = 1'b1;
            tap_a  = bus.e_addr;
        end
    end

    // Next state for the priority FSM, the host wait counter and the read/error tags.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        owner_d    = OWN_NONE;
        h_err_d    = 1'b0;

        if (!bus.h_req || h_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_LAST) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        case (state_q)
            ENG_PRI:  if (h_refused && (wait_cnt_q == WAIT_LAST)) state_d = HOST_PRI;
            HOST_PRI: if (h_gnt || !bus.h_req)                    state_d = ENG_PRI;
            default:  state_d = ENG_PRI;
        endcase

        if (h_gnt && !bus.h_we) begin
            owner_d = h_in_range ? OWN_HOST : OWN_HOST_OOR;
        end else if (e_gnt) begin
            owner_d = OWN_ENG;
        end

        h_err_d = h_gnt & (~h_in_range | h_wr_blocked);
    end

    // State registers; reset also drops any read that is still in flight.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q    <= ENG_PRI;
            wait_cnt_q <= '0;
            owner_q    <= OWN_NONE;
            h_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            owner_q    <= owner_d;
            h_err_q    <= h_err_d;
        end
    end

    assign bus.h_gnt    = h_gnt;
    assign bus.e_gnt    = e_gnt;
    assign bus.tap_EN   = tap_en;
    assign bus.tap_WE   = tap_we;
    assign bus.tap_A    = tap_a;
    assign bus.tap_Di   = tap_di;
    assign bus.h_err    = h_err_q;
    assign bus.h_rvalid = (owner_q == OWN_HOST) || (owner_q == OWN_HOST_OOR);
    assign bus.e_rvalid = (owner_q == OWN_ENG);
    assign bus.h_rdata  = (owner_q == OWN_HOST) ? bus.tap_Do : '0;
    assign bus.e_rdata  = (owner_q == OWN_ENG)  ? bus.tap_Do : '0;

`ifdef FIR_TAP_ARB_STATS_EN
    logic [15:0] host_stall_cnt_q, host_stall_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    // Saturating counters of host stall cycles and error pulses.
    always_comb begin
        host_stall_cnt_d = host_stall_cnt_q;
        err_cnt_d        = err_cnt_q;
        if (h_refused && (host_stall_cnt_q != 16'hFFFF)) host_stall_cnt_d = host_stall_cnt_q + 16'd1;
        if (h_err_q && (err_cnt_q != 8'hFF))             err_cnt_d        = err_cnt_q + 8'd1;
    end

    // Statistics registers.
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            host_stall_cnt_q <= '0;
            err_cnt_q        <= '0;
        end else begin
            host_stall_cnt_q <= host_stall_cnt_d;
            err_cnt_q        <= err_cnt_d;
        end
    end

    assign host_stall_cnt = host_stall_cnt_q;
    assign err_cnt        = err_cnt_q;
`endif

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Scoreboard bench for fir_tap_arbiter.
// The driver applies requests and checks the same-cycle grant and RAM controls
// against a reference model. It also queues the read and error responses that
// should appear one cycle later. The monitor pops the queue and compares the
// registered outputs every cycle.
module tb_fir_tap_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;
    localparam int TB = 'h20;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_tap_arbiter_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

`ifdef FIR_TAP_ARB_STATS_EN
    logic [15:0] host_stall_cnt;
    logic [7:0]  err_cnt;
`endif

    fir_tap_arbiter #(
        .pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT),
        .TAP_BASE(TB), .MAX_WAIT(MW)
    ) dut (
        .axis_clk (clk),
        .axis_rst (rst),
        .bus      (bus)
`ifdef FIR_TAP_ARB_STATS_EN
        ,
        .host_stall_cnt (host_stall_cnt),
        .err_cnt        (err_cnt)
`endif
    );

    // Tap RAM: one-cycle read latency, read-before-write.
    logic [DW-1:0] bram [0:1023];
    always @(posedge clk) begin
        if (bus.tap_EN) begin
            if (bus.tap_WE == 4'hF) bram[bus.tap_A[11:2]] <= bus.tap_Di;
            bus.tap_Do <= bram[bus.tap_A[11:2]];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [0:NT-1];
    int            refused_run;

    typedef struct {
        int            due;
        logic          hv;
        logic [DW-1:0] hd;
        logic          he;
        logic          ev;
        logic [DW-1:0] ed;
    } rsp_t;
    rsp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Drive one cycle of requests, check the grant, predict the response.
    task automatic drive(input logic hreq, input logic hwe, input logic [AW-1:0] haddr,
                         input logic [DW-1:0] hwd, input logic ereq,
                         input logic [AW-1:0] eaddr, input logic busy,
                         output logic hg_o);
        logic host_pri, hg, eg, inr, en;
        logic [3:0]    we;
        logic [AW-1:0] a;
        logic [DW-1:0] di;
        logic [49:0]   exp_v, act_v;
        int ia, idx;
        rsp_t r;
        @(negedge clk);
        #1;
        bus.h_req = hreq; bus.h_we = hwe; bus.h_addr = haddr; bus.h_wdata = hwd;
        bus.e_req = ereq; bus.e_addr = eaddr; bus.eng_busy = busy;
        #1;
        // A host refused MAX_WAIT times in a row takes precedence.
        host_pri = (refused_run >= MW);
        if (host_pri) begin hg = hreq; eg = 1'b0; end
        else          begin eg = ereq; hg = hreq & ~ereq; end
        ia  = int'(haddr);
        inr = (ia >= TB) && (ia < TB + 4 * NT);
        idx = (ia - TB) / 4;
        en = 1'b0; we = 4'h0; a = '0; di = '0;
        if (hg && inr && !(hwe && busy)) begin
            en = 1'b1; a = AW'(ia - TB);
            if (hwe) begin we = 4'hF; di = hwd; end
        end else if (eg) begin
            en = 1'b1; a = eaddr;
        end
        exp_v = {hg, eg, en, we, a, di};
        act_v = {bus.h_gnt, bus.e_gnt, bus.tap_EN, bus.tap_WE, bus.tap_A, bus.tap_Di};
        checks++;
        if (exp_v !== act_v) begin
            errors++;
            $display("FAIL ctl cyc=%0d actual gnt_h/e=%b%b en=%b we=%h a=%h di=%h required gnt_h/e=%b%b en=%b we=%h a=%h di=%h",
                     cyc, bus.h_gnt, bus.e_gnt, bus.tap_EN, bus.tap_WE, bus.tap_A, bus.tap_Di,
                     hg, eg, en, we, a, di);
        end
        r = '{due: cyc + 1, hv: 1'b0, hd: '0, he: 1'b0, ev: 1'b0, ed: '0};
        if (hg) begin
            r.he = !inr || (hwe && busy);
            if (!hwe) begin
                r.hv = 1'b1;
                r.hd = inr ? ref_mem[idx] : '0;
            end else if (inr && !busy) begin
                ref_mem[idx] = hwd;
            end
        end else if (eg) begin
            r.ev = 1'b1;
            r.ed = ref_mem[int'(eaddr) / 4];
        end
        if (r.hv || r.he || r.ev) q.push_back(r);
        refused_run = (hreq && !hg) ? refused_run + 1 : 0;
        hg_o = hg;
        $display("cyc=%0d h_req=%b we=%b addr=%h e_req=%b busy=%b -> h_gnt=%b e_gnt=%b",
                 cyc, hreq, hwe, haddr, ereq, busy, bus.h_gnt, bus.e_gnt);
    endtask

    // Monitor: compares registered responses against the queued predictions.
    initial begin
        rsp_t e;
        logic [67:0] ev_v, av_v;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                checks++;
                if ({bus.h_gnt, bus.h_rvalid, bus.h_rdata, bus.h_err, bus.e_gnt, bus.e_rvalid,
                     bus.e_rdata, bus.tap_WE, bus.tap_EN, bus.tap_Di, bus.tap_A} !== '0) begin
                    errors++;
                    $display("FAIL reset_outputs cyc=%0d actual h_rv=%b h_err=%b e_rv=%b en=%b required all zero",
                             cyc, bus.h_rvalid, bus.h_err, bus.e_rvalid, bus.tap_EN);
                end
            end else begin
                e = '{due: cyc, hv: 1'b0, hd: '0, he: 1'b0, ev: 1'b0, ed: '0};
                if (q.size() > 0 && q[0].due == cyc) e = q.pop_front();
                ev_v = {e.hv, e.hd, e.he, e.ev, e.ed};
                av_v = {bus.h_rvalid, bus.h_rdata, bus.h_err, bus.e_rvalid, bus.e_rdata};
                checks++;
                if (ev_v !== av_v) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d actual h_rv=%b h_rd=%h h_err=%b e_rv=%b e_rd=%h required h_rv=%b h_rd=%h h_err=%b e_rv=%b e_rd=%h",
                             cyc, bus.h_rvalid, bus.h_rdata, bus.h_err, bus.e_rvalid, bus.e_rdata,
                             e.hv, e.hd, e.he, e.ev, e.ed);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic          g;
        logic          p_hreq, p_hwe;
        logic [AW-1:0] p_haddr;
        logic [DW-1:0] p_hwd;
        int            r;

        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.e_req = 0; bus.e_addr = '0; bus.eng_busy = 0;
        for (int i = 0; i < 1024; i++) bram[i] = 32'hA000_0000 + DW'(i);
        for (int i = 0; i < NT; i++)   ref_mem[i] = 32'hA000_0000 + DW'(i);
        refused_run = 0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;

        // Write then read back a tap
        drive(1, 1, 12'h024, 32'd5, 0, '0, 0, g);
        drive(1, 0, 12'h024, '0,    0, '0, 0, g);
        // Out-of-range write and read
        drive(1, 1, 12'h080, 32'h1234, 0, '0, 0, g);
        drive(1, 0, 12'h080, '0,       0, '0, 0, g);
        // Write refused while engine busy, readback afterwards keeps old value
        drive(1, 1, 12'h028, 32'd7, 0, '0, 1, g);
        drive(1, 0, 12'h028, '0,    0, '0, 1, g);
        drive(1, 0, 12'h028, '0,    0, '0, 0, g);
        // Starvation: engine and host both hold requests
        for (int i = 0; i < 7; i++) drive(1, 0, 12'h020, '0, 1, 12'h008, 1, g);
        drive(0, 0, '0, '0, 0, '0, 0, g);
        // Engine read followed immediately by host read
        drive(0, 0, '0,      '0, 1, 12'h000, 1, g);
        drive(1, 0, 12'h02C, '0, 0, '0,      1, g);
        // Last-tap boundary and the first address past it
        drive(1, 1, 12'h048, 32'hCAFE_F00D, 0, '0, 0, g);
        drive(1, 0, 12'h048, '0,            0, '0, 0, g);
        drive(1, 0, 12'h04C, '0,            0, '0, 0, g);

        // Reset asserted while a host read is in flight
        drive(1, 0, 12'h030, '0, 0, '0, 0, g);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.h_req = 0; bus.e_req = 0;
        refused_run = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        // Engine priority again after reset
        drive(1, 0, 12'h030, '0, 1, 12'h004, 0, g);
        drive(1, 0, 12'h030, '0, 0, '0,      0, g);

        // Random traffic; a refused host request is held unchanged.
        p_hreq = 0; p_hwe = 0; p_haddr = '0; p_hwd = '0; g = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!(p_hreq && !g)) begin
                p_hreq = ($urandom % 3) != 0;
                p_hwe  = $urandom % 2;
                p_hwd  = $urandom;
                r = $urandom % 8;
                case (r)
                    0: p_haddr = 12'h080;
                    1: p_haddr = 12'h01C;
                    2: p_haddr = 12'h04C;
                    default: p_haddr = AW'(TB + 4 * int'($urandom_range(0, NT - 1)));
                endcase
            end
            drive(p_hreq, p_hwe, p_haddr, p_hwd, ($urandom % 10) < 7,
                  AW'(4 * int'($urandom_range(0, NT - 1))), ($urandom % 4) == 0, g);
        end
        drive(0, 0, '0, '0, 0, '0, 0, g);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual pending=%0d required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
